// File: rtl/frame_capture_ctrl.sv
// Frame-gated write-path controller between camera capture and frame buffer (live/freeze/snapshot).
// Optional word-count check: define FRAME_CAPTURE_CTRL_WORDCHECK_EN to build the short_frame logic.
module frame_capture_ctrl #(
    parameter int FRAME_WORDS = 76800,
    parameter int ADDR_W      = 17,
    parameter int DATA_W      = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vsync,
    input  logic              we_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              cmd_live,
    input  logic              cmd_freeze,
    input  logic              cmd_snap,
    output logic              we_out,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] data_out,
    output logic [1:0]        mode,
    output logic              frame_done,
    output logic [7:0]        frame_count,
    output logic              overrun,
    output logic              short_frame
);

    localparam logic [1:0]      ST_LIVE = 2'd0;
    localparam logic [1:0]      ST_HOLD = 2'd1;
    localparam logic [1:0]      ST_SNAP = 2'd2;
    localparam logic [ADDR_W:0] LP_FW   = (ADDR_W+1)'(FRAME_WORDS);

    logic              r_vsync_q;
    logic              r_synced;
    logic              r_pend_live, r_pend_frz, r_pend_snap;
    logic [1:0]        r_state;
    logic [ADDR_W:0]   r_wcnt;

    logic              w_vs_rise;
    logic              w_req_live, w_req_frz, w_req_snap;
    logic              w_gated_st, w_gate, w_in_range, w_accept, w_drop, w_frame_end;
    logic [1:0]        w_state_nxt;

    assign w_vs_rise   = vsync & ~r_vsync_q;
    // A pulse landing on the boundary cycle still counts for that boundary.
    assign w_req_live  = r_pend_live | cmd_live;
    assign w_req_frz   = r_pend_frz  | cmd_freeze;
    assign w_req_snap  = r_pend_snap | cmd_snap;
    assign w_gated_st  = (r_state == ST_LIVE) || (r_state == ST_SNAP);
    // r_synced keeps the gate shut until a blanking period is seen, so a
    // reset released mid-frame never lets a partial frame into the buffer.
    assign w_gate      = w_gated_st & r_synced & ~vsync;
    assign w_in_range  = {1'b0, addr_in} < LP_FW;
    assign w_accept    = we_in & w_gate & w_in_range;
    assign w_drop      = we_in & w_gate & ~w_in_range;
    assign w_frame_end = w_vs_rise & w_gated_st & (r_wcnt != '0);
    assign mode        = r_state;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_LIVE: begin
                if (w_req_frz)       w_state_nxt = ST_HOLD;
                else if (w_req_snap) w_state_nxt = ST_SNAP;
            end
            ST_HOLD: begin
                if (w_req_snap)      w_state_nxt = ST_SNAP;
                else if (w_req_live) w_state_nxt = ST_LIVE;
            end
            ST_SNAP: begin
                if (w_req_frz)       w_state_nxt = ST_HOLD;
                else if (w_req_live) w_state_nxt = ST_LIVE;
                else                 w_state_nxt = ST_HOLD;
            end
            default:                 w_state_nxt = ST_LIVE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync_q   <= 1'b0;
            r_synced    <= 1'b0;
            r_pend_live <= 1'b0;
            r_pend_frz  <= 1'b0;
            r_pend_snap <= 1'b0;
            r_state     <= ST_LIVE;
            r_wcnt      <= '0;
            we_out      <= 1'b0;
            addr_out    <= '0;
            data_out    <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            overrun     <= 1'b0;
        end else begin
            r_vsync_q <= vsync;
            if (vsync) r_synced <= 1'b1;

            if (w_vs_rise) begin
                r_pend_live <= 1'b0;
                r_pend_frz  <= 1'b0;
                r_pend_snap <= 1'b0;
                r_state     <= w_state_nxt;
            end else begin
                r_pend_live <= w_req_live;
                r_pend_frz  <= w_req_frz;
                r_pend_snap <= w_req_snap;
            end

            we_out   <= w_accept;
            addr_out <= addr_in;
            data_out <= data_in;
            if (w_drop) overrun <= 1'b1;

            if (w_vs_rise)                      r_wcnt <= '0;
            else if (w_accept && r_wcnt != LP_FW) r_wcnt <= r_wcnt + (ADDR_W+1)'(1);

            frame_done <= w_frame_end;
            if (w_frame_end) frame_count <= frame_count + 8'd1;
        end
    end

`ifdef FRAME_CAPTURE_CTRL_WORDCHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             short_frame <= 1'b0;
        else if (w_frame_end && r_wcnt != LP_FW) short_frame <= 1'b1;
    end
`else
    assign short_frame = 1'b0;
`endif

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Directed bench for frame_capture_ctrl using a reduced frame size so whole frames stay short.
module tb_frame_capture_ctrl;
    localparam int FW     = 64;
    localparam int ADDR_W = 17;
    localparam int DATA_W = 12;

`ifdef FRAME_CAPTURE_CTRL_WORDCHECK_EN
    localparam logic SHORT_EXP = 1'b1;
`else
    localparam logic SHORT_EXP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              vsync = 1'b0;
    logic              we_in = 1'b0;
    logic [ADDR_W-1:0] addr_in = '0;
    logic [DATA_W-1:0] data_in = '0;
    logic              cmd_live = 1'b0, cmd_freeze = 1'b0, cmd_snap = 1'b0;
    logic              we_out;
    logic [ADDR_W-1:0] addr_out;
    logic [DATA_W-1:0] data_out;
    logic [1:0]        mode;
    logic              frame_done;
    logic [7:0]        frame_count;
    logic              overrun;
    logic              short_frame;

    int n_tests = 0;
    int n_fail  = 0;
    int wcnt    = 0;
    int dcnt    = 0;
    int wo;
    int dn;

    frame_capture_ctrl #(.FRAME_WORDS(FW), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .we_in(we_in), .addr_in(addr_in),
        .data_in(data_in), .cmd_live(cmd_live), .cmd_freeze(cmd_freeze), .cmd_snap(cmd_snap),
        .we_out(we_out), .addr_out(addr_out), .data_out(data_out), .mode(mode),
        .frame_done(frame_done), .frame_count(frame_count), .overrun(overrun),
        .short_frame(short_frame)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (we_out)     wcnt++;
        if (frame_done) dcnt++;
    endtask

    task automatic blank();
        vsync = 1'b1;
        repeat (3) tick();
    endtask

    // One frame of n writes; cmd = {snap, freeze, live} pulsed halfway; ends with a vsync rise.
    task automatic frame(input string tag, input int n, input logic [2:0] cmd, input logic gate_exp,
                         output int w, output int d);
        wcnt = 0;
        dcnt = 0;
        vsync = 1'b0;
        for (int i = 0; i < n; i++) begin
            we_in   = 1'b1;
            addr_in = ADDR_W'(i);
            data_in = DATA_W'(i + 'h5A0);
            if (i == n / 2) {cmd_snap, cmd_freeze, cmd_live} = cmd;
            tick();
            {cmd_snap, cmd_freeze, cmd_live} = 3'b000;
            if (i == 0) begin
                check({tag, " first we_out"}, we_out, gate_exp);
                check({tag, " first addr_out"}, addr_out, 0);
                check({tag, " first data_out"}, data_out, 'h5A0);
            end
        end
        we_in = 1'b0;
        tick();
        blank();
        w = wcnt;
        d = dcnt;
    endtask

    initial begin
        repeat (3) tick();
        check("reset we_out", we_out, 0);
        check("reset mode", mode, 0);
        check("reset frame_done", frame_done, 0);
        check("reset frame_count", frame_count, 0);
        check("reset overrun", overrun, 0);
        check("reset short_frame", short_frame, 0);
        rst_n = 1'b1;
        tick();
        blank();

        frame("f1", FW, 3'b000, 1'b1, wo, dn);
        check("f1 writes", wo, FW);
        check("f1 done", dn, 1);
        frame("f2", FW, 3'b000, 1'b1, wo, dn);
        check("f2 writes", wo, FW);
        check("f2 done", dn, 1);
        check("f2 count", frame_count, 2);
        check("f2 short", short_frame, 0);

        frame("f3", FW, 3'b010, 1'b1, wo, dn);
        check("f3 writes", wo, FW);
        check("f3 count", frame_count, 3);
        check("f3 mode", mode, 1);
        frame("f4", FW, 3'b000, 1'b0, wo, dn);
        check("f4 writes", wo, 0);
        check("f4 done", dn, 0);
        frame("f5", FW, 3'b100, 1'b0, wo, dn);
        check("f5 writes", wo, 0);
        check("f5 count", frame_count, 3);
        check("f5 mode snap", mode, 2);
        frame("f6", FW, 3'b000, 1'b1, wo, dn);
        check("f6 writes", wo, FW);
        check("f6 count", frame_count, 4);
        check("f6 mode hold", mode, 1);

        frame("f7", FW, 3'b001, 1'b0, wo, dn);
        check("f7 writes", wo, 0);
        check("f7 mode live", mode, 0);
        frame("f8", FW, 3'b110, 1'b1, wo, dn);
        check("f8 writes", wo, FW);
        check("f8 mode hold", mode, 1);
        check("f8 count", frame_count, 5);
        frame("f9", FW, 3'b001, 1'b0, wo, dn);
        check("f9 writes", wo, 0);
        check("f9 mode live", mode, 0);

        frame("f10", FW - 1, 3'b000, 1'b1, wo, dn);
        check("f10 writes", wo, FW - 1);
        check("f10 count", frame_count, 6);
        check("f10 short", short_frame, SHORT_EXP);

        vsync = 1'b0;
        we_in = 1'b1; addr_in = ADDR_W'(FW);
        tick();
        check("oob we_out", we_out, 0);
        check("oob overrun", overrun, 1);
        addr_in = ADDR_W'(FW - 1);
        tick();
        check("last addr we_out", we_out, 1);
        we_in = 1'b0;
        tick();
        blank();
        check("overrun sticky", overrun, 1);
        check("f11 count", frame_count, 7);

        wcnt = 0;
        vsync = 1'b0;
        we_in = 1'b1; addr_in = ADDR_W'(3);
        repeat (3) tick();
        check("pre-reset writes", wcnt, 3);
        #2 rst_n = 1'b0;
        #1;
        check("async we_out", we_out, 0);
        check("rst mode", mode, 0);
        check("rst count", frame_count, 0);
        check("rst overrun", overrun, 0);
        tick();
        rst_n = 1'b1;
        wcnt = 0;
        repeat (4) tick();
        check("post-reset gated off", wcnt, 0);
        we_in = 1'b0;
        blank();
        frame("f12", FW, 3'b000, 1'b1, wo, dn);
        check("f12 writes", wo, FW);
        check("f12 count", frame_count, 1);
        check("f12 short", short_frame, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/frame_capture_ctrl.md
# frame_capture_ctrl

Write-path controller between `ov7670_capture` and `frame_buffer`: decides, frame by frame, whether camera pixel writes reach the buffer. It implements live, freeze and single-snapshot modes driven by IR-decoded command pulses. All mode changes take effect only at frame boundaries, so the buffer never holds a torn frame. It also registers the write bus, drops out-of-range addresses and keeps frame statistics.

## Interface
- `FRAME_WORDS`, 76800: words per frame (320x240); valid addresses are 0..FRAME_WORDS-1.
- `ADDR_W`, 17: address width.
- `DATA_W`, 12: pixel word width.
- `clk` in 1: camera pixel clock (`ov7670_pclk`); the only clock.
- `rst_n` in 1: asynchronous active-low reset.
- `vsync` in 1: camera vsync; high during vertical blanking.
- `we_in` in 1: write strobe from capture.
- `addr_in` in ADDR_W: write address from capture.
- `data_in` in DATA_W: write data from capture.
- `cmd_live` in 1: one-cycle pulse, already synchronised to `clk`.
- `cmd_freeze` in 1: one-cycle pulse, already synchronised to `clk`.
- `cmd_snap` in 1: one-cycle pulse, already synchronised to `clk`.
- `we_out` out 1: registered write strobe to `frame_buffer`.
- `addr_out` out ADDR_W: registered address to `frame_buffer`.
- `data_out` out DATA_W: registered data to `frame_buffer`.
- `mode` out 2: current state; LIVE=0, HOLD=1, SNAP=2.
- `frame_done` out 1: one-cycle pulse when a gated frame completes.
- `frame_count` out 8: number of completed gated frames; wraps from 255 to 0.
- `overrun` out 1: sticky; set when a write is dropped for addr_in >= FRAME_WORDS.
- `short_frame` out 1: sticky word-count error flag; see Configuration.

## Operation
- Boundary detect: `vsync_q` is `vsync` registered. `vs_rise = vsync & ~vsync_q`.
- Pending flags: each cmd pulse sets its own pending bit. A bit stays set until consumed at the next `vs_rise`; repeated pulses are idempotent.
- Consumption: at `vs_rise` all pending bits clear, whether or not they changed the state.
- Priority when several bits are pending: freeze > snap > live.
- A cmd pulse in the same cycle as `vs_rise` counts as pending for that boundary.
- State transitions, evaluated only on `vs_rise`:
  - LIVE: freeze -> HOLD; snap -> SNAP; otherwise stay in LIVE.
  - HOLD: snap -> SNAP; live -> LIVE; otherwise stay in HOLD.
  - SNAP: freeze -> HOLD; live -> LIVE; otherwise -> HOLD. SNAP therefore lasts exactly one frame.
- Gate open means state is LIVE or SNAP, and `vsync`=0.
- Accepted write: `we_in` & gate open & `addr_in` < FRAME_WORDS.
- A write that passes the gate but has `addr_in` >= FRAME_WORDS is dropped and sets `overrun`.
- Frame word counter (ADDR_W+1 bits):
  - Clears on `vs_rise`.
  - Increments on each accepted write.
  - Saturates at FRAME_WORDS.
- `frame_done` and `frame_count`: on `vs_rise`, if the pre-transition state was LIVE or SNAP and the word counter is nonzero, `frame_done` pulses and `frame_count` increments.
- `overrun` clears only on reset.

## Timing
- Reset: state = LIVE and all pending bits clear. All outputs are 0, except `mode`=0 (LIVE).
- Write path latency is 1 cycle: `we_out`, `addr_out` and `data_out` are the registered `we_in`/`addr_in`/`data_in` from the previous cycle, with `we_out` gated. `addr_out` and `data_out` update every cycle regardless of gating.
- Effective boundary is the cycle after the `vs_rise` cycle:
  - `mode` updates on the clock edge that samples `vs_rise`.
  - `frame_done` is high for the cycle after that edge.
  - `frame_count` updates on the same edge as `mode`.
- Reset asserted mid-frame: `we_out` drops to 0 asynchronously and the state returns to LIVE. The first post-reset gated frame begins at the next `vsync` low period.

## Configuration
- `FRAME_CAPTURE_CTRL_WORDCHECK_EN` defined:
  - At each `vs_rise` that ends a gated frame, a word count not equal to FRAME_WORDS sets `short_frame`.
  - `short_frame` is sticky until reset.
- Macro undefined: `short_frame` is tied to 0 and no compare logic is built.

## Test plan
- Reset, then 2 full frames (76800 writes each) in LIVE -> `we_out` mirrors `we_in` one cycle later; `frame_done` pulses twice; `frame_count`=2; `short_frame`=0.
- `cmd_freeze` mid-frame 3 -> frame 3 completes fully (76800 `we_out`); `mode`=1 after the next `vs_rise`; frames 4-5 produce zero `we_out`; `frame_count` unchanged.
- From HOLD, `cmd_snap` -> exactly one frame written; `mode` goes 2 then 1; `frame_count` +1.
- `cmd_snap` and `cmd_freeze` in the same cycle while in LIVE -> next state HOLD and the snap request is discarded.
- `we_in` with `addr_in`=76800 -> no `we_out`; `overrun`=1 and it stays set.
- WORDCHECK_EN build, frame of 76799 writes -> `short_frame`=1 after `vs_rise`. Non-EN build, same stimulus -> `short_frame`=0.
